// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N producers, with a per-grant burst limit.
// Optional stall counter output enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int B         = 8,
  parameter int N         = 4,
  parameter int I         = 2,
  parameter int MAX_BURST = 4,
  parameter int C         = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*B-1:0] data_in,
  input  logic           full,
  output logic [N-1:0]   grant,
  output logic           wr,
  output logic [B-1:0]   w_data,
  output logic [I-1:0]   owner,
  output logic           busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [I-1:0]   owner_q, owner_d;
  logic [C-1:0]   burst_cnt_q, burst_cnt_d;

  logic           accept;
  logic           release_grant;
  logic           found;
  logic [I-1:0]   winner;
  logic [I-1:0]   scan_idx;

  assign busy   = (state_q == GRANT);
  assign grant  = grant_q;
  assign owner  = owner_q;
  assign accept = busy & req[owner_q] & ~full;
  assign wr     = accept;
  assign w_data = data_in[owner_q*B +: B];

  assign release_grant = ~req[owner_q] |
                         (accept & (burst_cnt_q == C'(MAX_BURST - 1)));

  // Scan starts just after the current owner and wraps, so the owner is considered last.
  always_comb begin
    found    = 1'b0;
    winner   = owner_q;
    scan_idx = owner_q;
    for (int k = 1; k <= N; k++) begin
      scan_idx = owner_q + I'(k);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = GRANT;
          grant_d     = N'(1) << winner;
          owner_d     = winner;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          if (found) begin
            grant_d     = N'(1) << winner;
            owner_d     = winner;
            burst_cnt_d = '0;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + C'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= I'(N - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where the granted producer waits on a full FIFO.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (busy && req[owner_q] && full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a cycle-level reference model queues expected state and
// written words; a negedge monitor compares them against the DUT.
module tb_fifo_wr_arbiter;
  localparam int B         = 8;
  localparam int N         = 4;
  localparam int I         = 2;
  localparam int MAX_BURST = 4;
  localparam int C         = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*B-1:0] data_in = '0;
  logic           full = 1'b0;
  logic [N-1:0]   grant;
  logic           wr;
  logic [B-1:0]   w_data;
  logic [I-1:0]   owner;
  logic           busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]    stall_cnt;
`endif

  fifo_wr_arbiter #(.B(B), .N(N), .I(I), .MAX_BURST(MAX_BURST), .C(C)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .full(full),
    .grant(grant), .wr(wr), .w_data(w_data), .owner(owner), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] grant;
    logic         busy;
    logic [I-1:0] owner;
    logic         wr;
    logic [15:0]  stall;
  } exp_t;

  exp_t             exp_q[$];
  logic [I+B-1:0]   word_q[$];

  // Reference model: whole-transaction view of the arbiter.
  bit               m_busy;
  int               m_owner;
  int               m_cnt;
  int               m_stall;
  logic [B-1:0]     word_val[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int search(input int from, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input logic r, input logic [N-1:0] rq, input logic f);
    exp_t e;
    bit   acc;
    int   w;
    @(posedge clk);
    #1;
    reset = r;
    req   = rq;
    full  = f;
    for (int i = 0; i < N; i++) data_in[i*B +: B] = B'(8'hA0 + 8'(i * 16)) + word_val[i];
    if (r) begin
      m_busy  = 0;
      m_owner = N - 1;
      m_cnt   = 0;
      m_stall = 0;
    end
    acc     = m_busy && rq[m_owner] && !f;
    e.grant = m_busy ? (N'(1) << m_owner) : '0;
    e.busy  = m_busy;
    e.owner = I'(m_owner);
    e.wr    = acc;
    e.stall = 16'(m_stall);
    exp_q.push_back(e);
    if (acc) begin
      word_q.push_back({I'(m_owner), data_in[m_owner*B +: B]});
      word_val[m_owner] = word_val[m_owner] + 1'b1;
    end
    if (r) begin
      #1;
      check("async_reset_grant", 32'(grant), 32'd0);
      check("async_reset_wr", 32'(wr), 32'd0);
    end else if (!m_busy) begin
      w = search(m_owner, rq);
      if (w >= 0) begin
        m_busy  = 1;
        m_owner = w;
        m_cnt   = 0;
      end
    end else begin
      if (rq[m_owner] && f && m_stall < 65535) m_stall++;
      if (acc) m_cnt++;
      if (!rq[m_owner] || m_cnt == MAX_BURST) begin
        w = search(m_owner, rq);
        if (w >= 0) begin
          m_owner = w;
          m_cnt   = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  initial begin : monitor
    exp_t           e;
    logic [I+B-1:0] wd;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("busy", 32'(busy), 32'(e.busy));
        check("owner", 32'(owner), 32'(e.owner));
        check("wr", 32'(wr), 32'(e.wr));
`ifdef FIFO_ARB_STATS_EN
        check("stall_cnt", 32'(stall_cnt), 32'(e.stall));
`endif
        if (wr) begin
          if (word_q.size() == 0) begin
            check("unexpected_write", 32'(1), 32'(0));
          end else begin
            wd = word_q.pop_front();
            check("w_data", 32'({owner, w_data}), 32'(wd));
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] rr;
    for (int i = 0; i < N; i++) word_val[i] = '0;
    m_busy = 0; m_owner = N - 1; m_cnt = 0; m_stall = 0;

    // Reset, then idle with no requests.
    repeat (2) cycle(1'b1, 4'b0000, 1'b0);
    repeat (5) cycle(1'b0, 4'b0000, 1'b0);

    // Single requester: bursts of 4, re-granted to itself.
    repeat (12) cycle(1'b0, 4'b0001, 1'b0);

    // All requesting: rotation with no idle bubble.
    repeat (22) cycle(1'b0, 4'b1111, 1'b0);

    // Requester 2 stalled by full after 2 accepts.
    cycle(1'b1, 4'b0000, 1'b0);
    repeat (3) cycle(1'b0, 4'b0100, 1'b0);
    repeat (3) cycle(1'b0, 4'b0100, 1'b1);
    repeat (4) cycle(1'b0, 4'b0100, 1'b0);

    // req[1] drops after one accept while req[3] waits.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0010, 1'b0);
    cycle(1'b0, 4'b1010, 1'b0);
    repeat (6) cycle(1'b0, 4'b1000, 1'b0);

    // req dropped while full: grant released anyway.
    repeat (2) cycle(1'b0, 4'b0001, 1'b1);
    repeat (2) cycle(1'b0, 4'b0000, 1'b1);

    // Reset mid-burst, then lowest requesting index wins.
    repeat (3) cycle(1'b0, 4'b1100, 1'b0);
    cycle(1'b1, 4'b1100, 1'b0);
    repeat (4) cycle(1'b0, 4'b1100, 1'b0);

    // Randomized traffic with held requests, full bursts and rare resets.
    rr = 4'b0101;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(4) == 0) rr = N'($urandom);
      cycle(($urandom_range(199) == 0), rr, ($urandom_range(3) == 0));
    end

    repeat (3) cycle(1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    check("drain_words", 32'(word_q.size()), 32'd0);
    check("drain_states", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
